// File: rtl/gate_exerciser_pkg.sv
// Shared types, gate bit positions and the golden truth table for the gate exerciser.
// Both the exerciser and the testbench use these definitions.
package gate_exerciser_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_e;

  localparam int NUM_GATES = 7;
  localparam int G_AND     = 0;
  localparam int G_OR      = 1;
  localparam int G_NOTX    = 2;
  localparam int G_NAND    = 3;
  localparam int G_NOR     = 4;
  localparam int G_XOR     = 5;
  localparam int G_XNOR    = 6;

  function automatic logic [NUM_GATES-1:0] golden(input logic x, input logic y);
    logic [NUM_GATES-1:0] e;
    e         = '0;
    e[G_AND]  = x & y;
    e[G_OR]   = x | y;
    e[G_NOTX] = ~x;
    e[G_NAND] = ~(x & y);
    e[G_NOR]  = ~(x | y);
    e[G_XOR]  = x ^ y;
    e[G_XNOR] = ~(x ^ y);
    return e;
  endfunction

endpackage

// File: rtl/gate_exerciser_if.sv
// Control, stimulus and result bundle between the gate exerciser and its host/gates block.
// master drives start/abort/g; slave is the exerciser itself.
interface gate_exerciser_if #(parameter int ERR_W = 8) ();

  logic                                    start;
  logic                                    abort;
  logic                                    x;
  logic                                    y;
  logic [gate_exerciser_pkg::NUM_GATES-1:0] g;
  logic                                    busy;
  logic                                    done;
  logic                                    pass;
  logic [ERR_W-1:0]                        err_count;
  logic [1:0]                              first_fail_vec;
  logic [gate_exerciser_pkg::NUM_GATES-1:0] first_fail_mask;

  modport master (
    output start, abort, g,
    input  x, y, busy, done, pass, err_count, first_fail_vec, first_fail_mask
  );

  modport slave (
    input  start, abort, g,
    output x, y, busy, done, pass, err_count, first_fail_vec, first_fail_mask
  );

endinterface

// File: rtl/gate_exerciser_golden.sv
// Expected gate outputs for the current stimulus vector.
// Thin wrapper so the golden table is usable as a standalone reference block.
module gate_golden
  import gate_exerciser_pkg::*;
(
  input  logic                 x_i,
  input  logic                 y_i,
  output logic [NUM_GATES-1:0] exp_o
);

  assign exp_o = golden(x_i, y_i);

endmodule

// File: rtl/gate_exerciser.sv
// Self-test sequencer for the basic-gate block: sweeps {x,y}, compares g to the golden table,
// and reports busy/done/pass, a saturating error count and the first failing vector.
//
// state  | meaning
// IDLE   | waiting for start (abort blocks it)
// SETTLE | stimulus held while the gates block settles
// CHECK  | g sampled and compared, next vector loaded
// DONE   | one-cycle done pulse, pass latched
module gate_exerciser
  import gate_exerciser_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ROUNDS        = 1,
  parameter int ERR_W         = 8
) (
  input logic             clk,
  input logic             rst_n,
  gate_exerciser_if.slave bus
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] ROUND_LAST  = RW'(ROUNDS - 1);

  state_e               state_q;
  logic [CW-1:0]        settle_q;
  logic [RW-1:0]        round_q;
  logic [1:0]           vec_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 pass_q;
  logic [ERR_W-1:0]     err_q;
  logic [ERR_W-1:0]     err_d;
  logic [1:0]           ffv_q;
  logic [NUM_GATES-1:0] ffm_q;
  logic [NUM_GATES-1:0] exp_w;
  logic [NUM_GATES-1:0] diff_w;
  logic                 mismatch_w;

  gate_golden u_golden (
    .x_i   (vec_q[1]),
    .y_i   (vec_q[0]),
    .exp_o (exp_w)
  );

  always_comb begin
    diff_w     = bus.g ^ exp_w;
    mismatch_w = |diff_w;
    err_d      = (err_q == {ERR_W{1'b1}}) ? err_q : err_q + ERR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      settle_q <= '0;
      round_q  <= '0;
      vec_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      ffv_q    <= '0;
      ffm_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            state_q  <= SETTLE;
            settle_q <= '0;
            round_q  <= '0;
            vec_q    <= '0;
            busy_q   <= 1'b1;
            pass_q   <= 1'b0;
            err_q    <= '0;
            ffv_q    <= '0;
            ffm_q    <= '0;
          end
        end
        SETTLE: begin
          if (bus.abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else if (settle_q == SETTLE_LAST) begin
            state_q <= CHECK;
          end else begin
            settle_q <= settle_q + CW'(1);
          end
        end
        CHECK: begin
          if (bus.abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else begin
            // err_q still zero means this is the first mismatch of the run
            if (mismatch_w) begin
              err_q <= err_d;
              if (err_q == '0) begin
                ffv_q <= vec_q;
                ffm_q <= diff_w;
              end
            end
            if (vec_q == 2'b11 && round_q == ROUND_LAST) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              if (vec_q == 2'b11) round_q <= round_q + RW'(1);
              vec_q    <= vec_q + 2'd1;
              settle_q <= '0;
              state_q  <= SETTLE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          pass_q  <= (err_q == '0);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.x               = vec_q[1];
  assign bus.y               = vec_q[0];
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.err_count       = err_q;
  assign bus.first_fail_vec  = ffv_q;
  assign bus.first_fail_mask = ffm_q;

endmodule
